// File: rtl/cond_unit_it.sv
// Conditional execution unit: banked NZCV flags, ARM condition decode, control gating,
// and a Thumb-style IT sequencer that predicates up to ITMAX following instructions.
module cond_unit_it #(
    parameter  int NCTX  = 2,
    parameter  int ITMAX = 4,
    localparam int CTXW  = (NCTX > 1) ? $clog2(NCTX) : 1,
    localparam int LW    = $clog2(ITMAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Valid,
    input  logic             Stall,
    input  logic [CTXW-1:0]  CtxSel,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [3:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             ITStart,
    input  logic [3:0]       ITCond,
    input  logic [ITMAX-1:0] ITMask,
    input  logic [LW-1:0]    ITLen,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic             storedCarry,
    output logic             InIT,
    output logic [LW-1:0]    ITRemain,
    output logic             ITErr
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state, state_nx;
    logic [3:0]       flags [NCTX];
    logic [3:0]       cur;
    logic [3:0]       it_cond_r, it_cond_nx;
    logic [ITMAX-1:0] mask_sh, mask_nx;
    logic [LW-1:0]    remain_nx;
    logic [3:0]       eff_cond;
    logic             go, it_idle, en, mask_bad;

    function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0:    eval_cond = z;
            4'h1:    eval_cond = ~z;
            4'h2:    eval_cond = cy;
            4'h3:    eval_cond = ~cy;
            4'h4:    eval_cond = n;
            4'h5:    eval_cond = ~n;
            4'h6:    eval_cond = v;
            4'h7:    eval_cond = ~v;
            4'h8:    eval_cond = cy & ~z;
            4'h9:    eval_cond = ~(cy & ~z);
            4'hA:    eval_cond = (n == v);
            4'hB:    eval_cond = (n != v);
            4'hC:    eval_cond = ~z & (n == v);
            4'hD:    eval_cond = ~(~z & (n == v));
            4'hE:    eval_cond = 1'b1;
            default: eval_cond = 1'b0;
        endcase
    endfunction

    assign cur         = flags[CtxSel];
    assign storedCarry = cur[1];
    assign InIT        = (state == ACTIVE);
    assign go          = Valid & ~Stall;
    assign it_idle     = ITStart & (state == IDLE);

    always_comb begin
        mask_bad = 1'b0;
        for (int unsigned i = 0; i < ITMAX; i++) begin
            if (i < 32'(ITLen) && !ITMask[i]) mask_bad = 1'b1;
        end
    end

    assign ITErr = go & ITStart & ((ITLen == '0) | (32'(ITLen) > ITMAX) |
                                   ((ITCond == 4'hE) & mask_bad) | (ITCond == 4'hF) |
                                   (state == ACTIVE));

    // The latched mask shifts right once per slot, so bit 0 is always the current slot.
    always_comb begin
        eff_cond = Cond;
        if (state == ACTIVE) eff_cond = mask_sh[0] ? it_cond_r : (it_cond_r ^ 4'b0001);
        CondEx   = it_idle ? 1'b1 : eval_cond(eff_cond, cur);
        en       = go & CondEx & ~it_idle;
        PCSrc    = PCS & en;
        RegWrite = RegW & en;
        MemWrite = MemW & en;
    end

    always_comb begin
        state_nx   = state;
        remain_nx  = ITRemain;
        mask_nx    = mask_sh;
        it_cond_nx = it_cond_r;
        if (go) begin
            case (state)
                IDLE: begin
                    if (ITStart && !ITErr) begin
                        state_nx   = ACTIVE;
                        it_cond_nx = ITCond;
                        mask_nx    = ITMask;
                        remain_nx  = ITLen;
                    end
                end
                ACTIVE: begin
                    if (PCSrc || ITRemain == LW'(1)) begin
                        state_nx  = IDLE;
                        remain_nx = '0;
                    end else begin
                        remain_nx = ITRemain - 1'b1;
                        mask_nx   = mask_sh >> 1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ITRemain  <= '0;
            mask_sh   <= '0;
            it_cond_r <= '0;
            flags     <= '{default: '0};
        end else begin
            state     <= state_nx;
            ITRemain  <= remain_nx;
            mask_sh   <= mask_nx;
            it_cond_r <= it_cond_nx;
            if (en) flags[CtxSel] <= (cur & ~FlagW) | (ALUFlags & FlagW);
        end
    end

endmodule

// File: tb/tb_cond_unit_it.sv
// Table-driven bench for cond_unit_it: each vector's expected outputs go through a
// scoreboard queue and are compared once the combinational outputs have settled.
module tb_cond_unit_it;

    logic       clk = 1'b0;
    logic       reset, Valid, Stall;
    logic [0:0] CtxSel;
    logic [3:0] Cond, ALUFlags, FlagW, ITCond, ITMask;
    logic       PCS, RegW, MemW, ITStart;
    logic [2:0] ITLen;
    logic       PCSrc, RegWrite, MemWrite, CondEx, storedCarry, InIT, ITErr;
    logic [2:0] ITRemain;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cond_unit_it #(.NCTX(2), .ITMAX(4)) dut (
        .clk(clk), .reset(reset), .Valid(Valid), .Stall(Stall), .CtxSel(CtxSel),
        .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
        .MemW(MemW), .ITStart(ITStart), .ITCond(ITCond), .ITMask(ITMask), .ITLen(ITLen),
        .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
        .storedCarry(storedCarry), .InIT(InIT), .ITRemain(ITRemain), .ITErr(ITErr)
    );

    // exp = {PCSrc, RegWrite, MemWrite, CondEx, storedCarry, InIT, ITRemain[2:0], ITErr}
    typedef struct {
        logic       rst, vl, st;
        logic [0:0] ctx;
        logic [3:0] cond, alu, fw;
        logic       pcs, rw, mw, its;
        logic [3:0] itc, itm;
        logic [2:0] itl;
        logic       chk;
        logic [9:0] exp;
    } vec_t;

    vec_t sb_q[$];
    int   vec_no = 0;

    task automatic apply(input vec_t v);
        vec_t       e;
        logic [9:0] got;
        reset = v.rst; Valid = v.vl; Stall = v.st; CtxSel = v.ctx; Cond = v.cond;
        ALUFlags = v.alu; FlagW = v.fw; PCS = v.pcs; RegW = v.rw; MemW = v.mw;
        ITStart = v.its; ITCond = v.itc; ITMask = v.itm; ITLen = v.itl;
        sb_q.push_back(v);
        #2;
        got = {PCSrc, RegWrite, MemWrite, CondEx, storedCarry, InIT, ITRemain, ITErr};
        e = sb_q.pop_front();
        if (e.chk) begin
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL vec%0d outputs got=%b exp=%b", vec_no, got, e.exp);
            end
        end
        vec_no++;
        @(negedge clk);
    endtask

    function automatic vec_t idle_vec();
        vec_t v;
        v = '{1'b0, 1'b1, 1'b0, 1'b0, 4'hE, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0,
              4'h0, 4'h0, 3'd0, 1'b1, 10'b0};
        return v;
    endfunction

    vec_t tbl [41];
    vec_t hv;

    initial begin
        // rst vl st ctx cond alu fw pcs rw mw its itc itm itl chk exp
        tbl[0]  = '{1,0,0,0,4'hE,4'h0,4'h0,0,0,0,0,4'h0,4'h0,3'd0,0,10'b0_0_0_0_0_0_000_0};
        tbl[1]  = '{0,0,0,0,4'hE,4'h0,4'h0,0,1,0,0,4'h0,4'h0,3'd0,1,10'b0_0_0_1_0_0_000_0};
        tbl[2]  = '{0,1,0,0,4'h0,4'h0,4'h0,0,1,0,0,4'h0,4'h0,3'd0,1,10'b0_0_0_0_0_0_000_0};
        tbl[3]  = '{0,1,0,0,4'hE,4'h4,4'h4,0,0,0,0,4'h0,4'h0,3'd0,1,10'b0_0_0_1_0_0_000_0};
        tbl[4]  = '{0,1,0,0,4'h0,4'h0,4'h0,0,1,0,0,4'h0,4'h0,3'd0,1,10'b0_1_0_1_0_0_000_0};
        tbl[5]  = '{0,1,0,0,4'h1,4'hF,4'hF,0,1,0,0,4'h0,4'h0,3'd0,1,10'b0_0_0_0_0_0_000_0};
        tbl[6]  = '{0,1,0,0,4'h0,4'h0,4'h0,0,1,1,0,4'h0,4'h0,3'd0,1,10'b0_1_1_1_0_0_000_0};
        tbl[7]  = '{0,1,0,0,4'hE,4'h0,4'h0,0,1,0,1,4'h0,4'h5,3'd3,1,10'b0_0_0_1_0_0_000_0};
        tbl[8]  = '{0,1,0,0,4'h1,4'h0,4'h0,0,1,0,0,4'h0,4'h0,3'd0,1,10'b0_1_0_1_0_1_011_0};
        tbl[9]  = '{0,1,0,0,4'h1,4'h0,4'h0,0,1,0,0,4'h0,4'h0,3'd0,1,10'b0_0_0_0_0_1_010_0};
        tbl[10] = '{0,1,0,0,4'h1,4'h0,4'h0,0,1,0,0,4'h0,4'h0,3'd0,1,10'b0_1_0_1_0_1_001_0};
        tbl[11] = '{0,1,0,0,4'hE,4'h0,4'h0,0,0,0,0,4'h0,4'h0,3'd0,1,10'b0_0_0_1_0_0_000_0};
        tbl[12] = '{0,1,0,0,4'hE,4'h0,4'h0,0,0,0,1,4'h0,4'h5,3'd3,1,10'b0_0_0_1_0_0_000_0};
        tbl[13] = '{0,1,0,0,4'hE,4'h0,4'h0,0,1,0,0,4'h0,4'h0,3'd0,1,10'b0_1_0_1_0_1_011_0};
        tbl[14] = '{0,1,0,0,4'hE,4'h0,4'h0,0,1,0,0,4'h0,4'h0,3'd0,1,10'b0_0_0_0_0_1_010_0};
        tbl[15] = '{0,1,1,0,4'hE,4'h0,4'h0,0,1,0,0,4'h0,4'h0,3'd0,1,10'b0_0_0_1_0_1_001_0};
        tbl[16] = '{0,1,1,0,4'hE,4'h0,4'h0,0,1,0,0,4'h0,4'h0,3'd0,1,10'b0_0_0_1_0_1_001_0};
        tbl[17] = '{0,1,0,0,4'hE,4'h0,4'h0,0,1,0,0,4'h0,4'h0,3'd0,1,10'b0_1_0_1_0_1_001_0};
        tbl[18] = '{0,1,0,0,4'hE,4'h0,4'h0,0,0,0,0,4'h0,4'h0,3'd0,1,10'b0_0_0_1_0_0_000_0};
        tbl[19] = '{0,1,0,0,4'hE,4'h0,4'h0,0,0,0,1,4'h0,4'h5,3'd3,1,10'b0_0_0_1_0_0_000_0};
        tbl[20] = '{0,1,0,0,4'hE,4'h0,4'h0,0,1,0,0,4'h0,4'h0,3'd0,1,10'b0_1_0_1_0_1_011_0};
        tbl[21] = '{1,1,0,0,4'hE,4'h0,4'h0,0,1,0,0,4'h0,4'h0,3'd0,0,10'b0_0_0_0_0_0_000_0};
        tbl[22] = '{0,0,0,0,4'h0,4'h0,4'h0,0,0,0,0,4'h0,4'h0,3'd0,1,10'b0_0_0_0_0_0_000_0};
        tbl[23] = '{0,1,0,0,4'hE,4'hA,4'hA,0,0,0,0,4'h0,4'h0,3'd0,1,10'b0_0_0_1_0_0_000_0};
        tbl[24] = '{0,0,0,1,4'h4,4'h0,4'h0,0,0,0,0,4'h0,4'h0,3'd0,1,10'b0_0_0_0_0_0_000_0};
        tbl[25] = '{0,0,0,0,4'h4,4'h0,4'h0,0,0,0,0,4'h0,4'h0,3'd0,1,10'b0_0_0_1_1_0_000_0};
        tbl[26] = '{0,1,0,0,4'hE,4'h0,4'h0,0,0,0,1,4'hE,4'h1,3'd2,1,10'b0_0_0_1_1_0_000_1};
        tbl[27] = '{0,0,0,0,4'hE,4'h0,4'h0,0,0,0,0,4'h0,4'h0,3'd0,1,10'b0_0_0_1_1_0_000_0};
        tbl[28] = '{0,1,0,0,4'hE,4'h0,4'h0,0,0,0,1,4'h0,4'hF,3'd0,1,10'b0_0_0_1_1_0_000_1};
        tbl[29] = '{0,1,0,0,4'hE,4'h0,4'h0,0,0,0,1,4'hF,4'hF,3'd3,1,10'b0_0_0_1_1_0_000_1};
        tbl[30] = '{0,1,0,0,4'hE,4'h0,4'h0,0,0,0,1,4'h0,4'hF,3'd5,1,10'b0_0_0_1_1_0_000_1};
        tbl[31] = '{0,1,0,0,4'hE,4'h0,4'h0,0,0,0,1,4'hE,4'hF,3'd3,1,10'b0_0_0_1_1_0_000_0};
        tbl[32] = '{0,1,0,0,4'h0,4'h0,4'h0,1,0,0,0,4'h0,4'h0,3'd0,1,10'b1_0_0_1_1_1_011_0};
        tbl[33] = '{0,1,0,0,4'hE,4'h0,4'h0,0,0,0,0,4'h0,4'h0,3'd0,1,10'b0_0_0_1_1_0_000_0};
        tbl[34] = '{0,1,0,0,4'hE,4'h0,4'h0,0,0,0,1,4'hE,4'hF,3'd2,1,10'b0_0_0_1_1_0_000_0};
        tbl[35] = '{0,1,0,0,4'hE,4'h0,4'h0,0,1,0,1,4'h0,4'hF,3'd1,1,10'b0_1_0_1_1_1_010_1};
        tbl[36] = '{0,1,0,0,4'hE,4'h0,4'h0,0,1,0,0,4'h0,4'h0,3'd0,1,10'b0_1_0_1_1_1_001_0};
        tbl[37] = '{0,1,0,0,4'hE,4'h0,4'h0,0,0,0,0,4'h0,4'h0,3'd0,1,10'b0_0_0_1_1_0_000_0};
        tbl[38] = '{0,1,0,0,4'hF,4'h0,4'h0,0,1,0,0,4'h0,4'h0,3'd0,1,10'b0_0_0_0_1_0_000_0};
        tbl[39] = '{0,1,0,0,4'h8,4'h0,4'h0,0,1,0,0,4'h0,4'h0,3'd0,1,10'b0_1_0_1_1_0_000_0};
        tbl[40] = '{0,1,0,0,4'hA,4'h0,4'h0,0,0,0,0,4'h0,4'h0,3'd0,1,10'b0_0_0_0_1_0_000_0};

        @(negedge clk);
        for (int i = 0; i < 41; i++) apply(tbl[i]);

        // Full-length block on CS (C=1 in bank 0): mask 1010 gives CC,CS,CC,CS.
        hv = idle_vec();
        hv.its = 1'b1; hv.itc = 4'h2; hv.itm = 4'b1010; hv.itl = 3'd4;
        hv.exp = 10'b0_0_0_1_1_0_000_0;
        apply(hv);
        for (int s = 0; s < 4; s++) begin
            logic [3:0] m;
            m = 4'b1010;
            hv = idle_vec();
            hv.rw = 1'b1;
            hv.exp = {1'b0, m[s], 1'b0, m[s], 1'b1, 1'b1, 3'(4 - s), 1'b0};
            apply(hv);
        end
        hv = idle_vec();
        hv.exp = 10'b0_0_0_1_1_0_000_0;
        apply(hv);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
